imem_loader: RTL and testbench

- Write-side counterpart to instruction fetch. Receives a program image as a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words.
- Drives the instruction memory's write port (addr/data/write_en/read_en) to store words from BASE_ADDR upward.
- Holds the core in reset until loading completes. Sits beside the fetch stage in the pd-level top.
- Memory port is muxed with fetch by the top using core_hold_o.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_byte_packer.sv | 38 +++
 rtl/imem_loader.sv | 105 ++++++++++
 tb/tb_imem_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory image loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;

  // Loader FSM encoding, kept as plain constants for legacy tooling.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream into 32-bit little-endian words. The fourth byte is
// merged combinationally so the completed word is usable on the same edge
// that accepts that byte.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [BYTE_IDX_W-1:0] idx_q;
  logic [23:0]           shift_q;

  // Track byte position and shift earlier bytes down so byte 0 ends at [7:0].
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (clear_i) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (push_i) begin
      idx_q   <= idx_q + 1'b1;
      shift_q <= {byte_i, shift_q[23:8]};
    end
  end

  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = push_i && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed program image into instruction memory and holds
// the core in reset until the image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
  parameter int                MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic [AWIDTH-1:0] addr_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              write_en_o,
  output logic              read_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              core_hold_o
);

  // Wide enough to hold MAX_WORDS itself, not just MAX_WORDS-1.
  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  count_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic [IDX_W-1:0]  next_idx;
  logic [DWIDTH-1:0] word_q;
  logic              push;
  logic              start_accept;
  logic [31:0]       pk_word;
  logic              pk_valid;

  assign push         = byte_valid_i && byte_ready_o;
  assign start_accept = start_i && (state_q == IDLE || state_q == DONE);
  assign next_idx     = word_idx_q + IDX_W'(1);

  imem_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_accept),
    .push_i       (push),
    .byte_i       (byte_data_i),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  // Next-state selection; the header is range-checked at full 32-bit width.
  always_comb begin
    // NOTE: defaulting state_d first keeps every path assigned, so no latch.
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = HDR;
      HDR: begin
        if (pk_valid) begin
          if (pk_word == 32'd0)                 state_d = DONE;
          else if (pk_word > 32'(MAX_WORDS))    state_d = ERR;
          else                                  state_d = DATA;
        end
      end
      DATA:  if (pk_valid) state_d = WRITE;
      WRITE: state_d = (next_idx == count_q) ? DONE : DATA;
      DONE:  if (start_i) state_d = HDR;
      ERR:   state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // State, word count, write index and the word awaiting its write cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      word_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_accept)
        word_idx_q <= '0;
      if (state_q == HDR && pk_valid)
        count_q <= IDX_W'(pk_word);
      if (state_q == DATA && pk_valid)
        word_q <= DWIDTH'(pk_word);
      if (state_q == WRITE)
        word_idx_q <= next_idx;
    end
  end

  assign byte_ready_o = (state_q == HDR) || (state_q == DATA);
  assign write_en_o   = (state_q == WRITE);
  assign read_en_o    = 1'b0;
  assign addr_o       = write_en_o ? BASE_ADDR + (AWIDTH'(word_idx_q) << 2) : '0;
  assign data_o       = write_en_o ? word_q : '0;
  assign busy_o       = (state_q == HDR) || (state_q == DATA) || (state_q == WRITE);
  assign done_o       = (state_q == DONE);
  assign error_o      = (state_q == ERR);
  assign core_hold_o  = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed sequences, a vector table and
// randomized images checked against an image-to-writes reference model.
module tb_imem_loader;

  localparam int          MAXW = 4096;
  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk          = 1'b0;
  logic        rst          = 1'b0;
  logic        start_i      = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i  = 8'h00;
  logic        byte_ready_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic        write_en_o, read_en_o, busy_o, done_o, error_o, core_hold_o;

  imem_loader #(
    .AWIDTH    (32),
    .DWIDTH    (32),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .addr_o       (addr_o),
    .data_o       (data_o),
    .write_en_o   (write_en_o),
    .read_en_o    (read_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .core_hold_o  (core_hold_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_wr_cyc = -1;
  int          last_xfer_cyc = -1;
  int          done_rise_cyc = -1;
  logic        done_prev = 1'b0;
  logic [63:0] wr_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  img_q[$];

  typedef struct {
    logic [31:0] hdr;
    int          gap_mode;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write capture and bus-idle check, sampled away from the active edge.
  always @(negedge clk) begin
    if (write_en_o) begin
      wr_q.push_back({addr_o, data_o});
      last_wr_cyc = cyc;
    end else begin
      check("bus_zero_when_idle", {read_en_o, addr_o, data_o}, 64'd0);
    end
    if (byte_valid_i && byte_ready_o) last_xfer_cyc = cyc;
    if (done_o && !done_prev) done_rise_cyc = cyc;
    done_prev = done_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start_i = 1'b0; byte_valid_i = 1'b0; byte_data_i = 8'h00;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit taken = 1'b0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    for (int k = 0; k < 50 && !taken; k++) begin
      @(negedge clk);
      if (byte_ready_o) taken = 1'b1;
      tick();
    end
    byte_valid_i = 1'b0;
    byte_data_i  = 8'($urandom);
    if (!taken) check("byte_accept_timeout", 0, 1);
    if (gap) tick();
  endtask

  // gap_mode: 0 = back-to-back, 1 = idle cycle after every byte, 2 = random.
  function automatic bit pick_gap(input int gap_mode);
    if (gap_mode == 1) return 1'b1;
    if (gap_mode == 2) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic send_word(input logic [31:0] w, input int gap_mode);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], pick_gap(gap_mode));
  endtask

  task automatic load(input logic [31:0] hdr, input int gap_mode);
    pulse_start();
    send_word(hdr, gap_mode);
    foreach (img_q[i]) send_byte(img_q[i], pick_gap(gap_mode));
  endtask

  // Reference model: word i of the image lands at BASE + 4*i, bytes little-endian.
  task automatic build_exp(input logic [31:0] hdr);
    exp_q.delete();
    if (hdr != 0 && hdr <= 32'(MAXW))
      for (int i = 0; i < int'(hdr); i++)
        exp_q.push_back({BASE + 32'(4 * i),
                         img_q[4*i+3], img_q[4*i+2], img_q[4*i+1], img_q[4*i]});
  endtask

  task automatic wait_end();
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done_o || error_o) seen = 1'b1;
    end
    if (!seen) check("end_timeout", 0, 1);
    tick();
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_write_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_write%0d_addr_data", tag, i), wr_q[i], exp_q[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},     64'(byte_ready_o), 64'd0);
    check({tag, "_write_en"},  64'(write_en_o),   64'd0);
    check({tag, "_done"},      64'(done_o),       64'd0);
    check({tag, "_error"},     64'(error_o),      64'd0);
    check({tag, "_core_hold"}, 64'(core_hold_o),  64'd1);
    check({tag, "_busy"},      64'(busy_o),       64'd0);
  endtask

  task automatic set_two_word_image();
    img_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    exp_q = '{64'h01000000_00000513, 64'h01000004_00100593};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{hdr: 32'd0,          gap_mode: 0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{hdr: 32'd1,          gap_mode: 0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{hdr: 32'd3,          gap_mode: 1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{hdr: 32'd5,          gap_mode: 2, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{hdr: 32'd4097,       gap_mode: 0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{hdr: 32'h0001_0000,  gap_mode: 0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[6] = '{hdr: 32'hFFFF_FFFF,  gap_mode: 1, exp_done: 1'b0, exp_err: 1'b1};

    // Reset values.
    do_reset();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();

    // Two-word load with a byte offered during the WRITE cycle.
    wr_q.delete();
    set_two_word_image();
    pulse_start();
    send_word(32'd2, 0);
    for (int i = 0; i < 4; i++) send_byte(img_q[i], 1'b0);
    byte_valid_i = 1'b1;
    byte_data_i  = img_q[4];
    @(negedge clk);
    check("write_cycle_ready_low", 64'(byte_ready_o), 64'd0);
    check("write_cycle_write_en",  64'(write_en_o),   64'd1);
    tick();
    @(negedge clk);
    check("after_write_ready_high", 64'(byte_ready_o), 64'd1);
    tick();
    byte_valid_i = 1'b0;
    for (int i = 5; i < 8; i++) send_byte(img_q[i], 1'b0);
    wait_end();
    check_writes("two_word");
    check("two_word_done",      64'(done_o),      64'd1);
    check("two_word_core_hold", 64'(core_hold_o), 64'd0);
    check("two_word_done_timing", 64'(done_rise_cyc), 64'(last_wr_cyc + 1));

    // Same image with valid toggling every other cycle.
    do_reset();
    wr_q.delete();
    set_two_word_image();
    load(32'd2, 1);
    wait_end();
    check_writes("gapped");
    check("gapped_done", 64'(done_o), 64'd1);

    // Exactly MAX_WORDS is accepted.
    do_reset();
    pulse_start();
    send_word(32'(MAXW), 0);
    @(negedge clk);
    check("max_words_busy",  64'(busy_o),       64'd1);
    check("max_words_error", 64'(error_o),      64'd0);
    check("max_words_ready", 64'(byte_ready_o), 64'd1);
    tick();

    // Reset after six bytes, then reload.
    do_reset();
    wr_q.delete();
    set_two_word_image();
    pulse_start();
    send_word(32'd2, 0);
    send_byte(img_q[0], 1'b0);
    send_byte(img_q[1], 1'b0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check_reset_outputs("midload_reset");
    tick();
    rst = 1'b1;
    check("midload_no_write", 64'(wr_q.size()), 64'd0);
    load(32'd2, 0);
    wait_end();
    check_writes("reload");
    check("reload_done", 64'(done_o), 64'd1);

    // Vector table: counts, boundaries and oversize headers.
    foreach (vecs[v]) begin
      do_reset();
      img_q.delete();
      if (!vecs[v].exp_err)
        for (int i = 0; i < 4 * int'(vecs[v].hdr); i++) img_q.push_back(8'($urandom));
      build_exp(vecs[v].hdr);
      wr_q.delete();
      done_rise_cyc = -1;
      load(vecs[v].hdr, vecs[v].gap_mode);
      wait_end();
      check_writes($sformatf("vec%0d", v));
      check($sformatf("vec%0d_done", v),      64'(done_o),      64'(vecs[v].exp_done));
      check($sformatf("vec%0d_error", v),     64'(error_o),     64'(vecs[v].exp_err));
      check($sformatf("vec%0d_core_hold", v), 64'(core_hold_o), 64'(!vecs[v].exp_done));
      if (vecs[v].exp_done)
        check($sformatf("vec%0d_done_timing", v), 64'(done_rise_cyc),
              (vecs[v].hdr == 0) ? 64'(last_xfer_cyc + 1) : 64'(last_wr_cyc + 1));
      if (vecs[v].exp_err) begin
        pulse_start();
        tick();
        tick();
        @(negedge clk);
        check($sformatf("vec%0d_err_sticky", v), 64'(error_o),      64'd1);
        check($sformatf("vec%0d_err_ready", v),  64'(byte_ready_o), 64'd0);
        check($sformatf("vec%0d_err_busy", v),   64'(busy_o),       64'd0);
        check($sformatf("vec%0d_err_writes", v), 64'(wr_q.size()),  64'd0);
        tick();
      end
    end

    // Randomized back-to-back images, restarting from DONE without reset.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      int cnt;
      cnt = $urandom_range(1, 6);
      img_q.delete();
      for (int i = 0; i < 4 * cnt; i++) img_q.push_back(8'($urandom));
      build_exp(32'(cnt));
      wr_q.delete();
      load(32'(cnt), 2);
      wait_end();
      check_writes($sformatf("rand%0d", r));
      check($sformatf("rand%0d_done", r), 64'(done_o), 64'd1);
      check($sformatf("rand%0d_done_timing", r), 64'(done_rise_cyc), 64'(last_wr_cyc + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
